// File: rtl/fifo_rr_banked.sv
// Banked round-robin elastic FIFO: BANKS circular queues striped in global order, independent enq/deq bank selectors.
// Registered outputs only (no enq-to-first bypass); enq is refused only when the target bank is full, deq only when the head bank is empty.
module fifo_rr_banked #(
    parameter int WIDTH = 96,
    parameter int BANKS = 2,
    parameter int DEPTH = 1,
    localparam int CAP  = BANKS * DEPTH,
    localparam int CW   = $clog2(CAP + 1)
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             in_enq__ENA,
    input  logic [WIDTH-1:0] in_enq_v,
    output logic             in_enq__RDY,
    input  logic             out_deq__ENA,
    output logic             out_deq__RDY,
    output logic [WIDTH-1:0] out_first,
    output logic             out_first__RDY,
    input  logic             flush__ENA,
    output logic [CW-1:0]    count
);
    localparam int SW = $clog2(BANKS);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW = $clog2(DEPTH + 1);

    logic [SW-1:0]    wsel, rsel;
    logic [PW-1:0]    wptr [BANKS];
    logic [PW-1:0]    rptr [BANKS];
    logic [OW-1:0]    occ  [BANKS];
    logic [WIDTH-1:0] mem  [BANKS][DEPTH];

    logic             enq_fire, deq_fire;
    logic [BANKS-1:0] bank_inc, bank_dec;

    // With a single entry per bank the pointer is a constant zero.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (DEPTH == 1) return '0;
        else            return p + PW'(1);
    endfunction

    function automatic logic [SW-1:0] sel_inc(input logic [SW-1:0] s);
        if (s == SW'(BANKS - 1)) return '0;
        else                     return s + SW'(1);
    endfunction

    assign in_enq__RDY    = (occ[wsel] != OW'(DEPTH));
    assign out_deq__RDY   = (occ[rsel] != '0);
    assign out_first__RDY = out_deq__RDY;
    assign out_first      = mem[rsel][rptr[rsel]];

    assign enq_fire = in_enq__ENA & in_enq__RDY;
    assign deq_fire = out_deq__ENA & out_deq__RDY;

    always_comb begin
        bank_inc = '0;
        bank_dec = '0;
        for (int b = 0; b < BANKS; b++) begin
            bank_inc[b] = enq_fire && (wsel == SW'(b));
            bank_dec[b] = deq_fire && (rsel == SW'(b));
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wsel  <= '0;
            rsel  <= '0;
            count <= '0;
            for (int b = 0; b < BANKS; b++) begin
                wptr[b] <= '0;
                rptr[b] <= '0;
                occ[b]  <= '0;
            end
        end else if (flush__ENA) begin
            wsel  <= '0;
            rsel  <= '0;
            count <= '0;
            for (int b = 0; b < BANKS; b++) begin
                wptr[b] <= '0;
                rptr[b] <= '0;
                occ[b]  <= '0;
            end
        end else begin
            if (enq_fire) begin
                wptr[wsel] <= ptr_inc(wptr[wsel]);
                wsel       <= sel_inc(wsel);
            end
            if (deq_fire) begin
                rptr[rsel] <= ptr_inc(rptr[rsel]);
                rsel       <= sel_inc(rsel);
            end
            // Same-bank enq+deq leaves that bank's occupancy untouched.
            for (int b = 0; b < BANKS; b++) begin
                if (bank_inc[b] && !bank_dec[b])
                    occ[b] <= occ[b] + OW'(1);
                else if (bank_dec[b] && !bank_inc[b])
                    occ[b] <= occ[b] - OW'(1);
            end
            case ({enq_fire, deq_fire})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage survives flush; only reset clears it.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int b = 0; b < BANKS; b++)
                for (int d = 0; d < DEPTH; d++)
                    mem[b][d] <= '0;
        end else if (enq_fire && !flush__ENA) begin
            mem[wsel][wptr[wsel]] <= in_enq_v;
        end
    end
endmodule

// File: tb/tb_fifo_rr_banked.sv
// Directed + random bench for fifo_rr_banked (BANKS=3, DEPTH=2) against a queue-based reference model.
module tb_fifo_rr_banked;
    localparam int WIDTH = 96;
    localparam int BANKS = 3;
    localparam int DEPTH = 2;
    localparam int CAP   = BANKS * DEPTH;
    localparam int CW    = $clog2(CAP + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             enq_ena, deq_ena, flush_ena;
    logic [WIDTH-1:0] enq_data;
    logic             enq_rdy, deq_rdy, first_rdy;
    logic [WIDTH-1:0] first;
    logic [CW-1:0]    count;

    int checks = 0;
    int errors = 0;

    // Model: global FIFO order; element number i (since last clear) lives in bank i % BANKS.
    logic [WIDTH-1:0] q[$];
    int               n_enq = 0;
    int               n_deq = 0;

    always #5 clk = ~clk;

    fifo_rr_banked #(.WIDTH(WIDTH), .BANKS(BANKS), .DEPTH(DEPTH)) dut (
        .CLK            (clk),
        .nRST           (rst_n),
        .in_enq__ENA    (enq_ena),
        .in_enq_v       (enq_data),
        .in_enq__RDY    (enq_rdy),
        .out_deq__ENA   (deq_ena),
        .out_deq__RDY   (deq_rdy),
        .out_first      (first),
        .out_first__RDY (first_rdy),
        .flush__ENA     (flush_ena),
        .count          (count)
    );

    function automatic int bank_occ(input int b);
        int n = 0;
        for (int i = n_deq; i < n_enq; i++)
            if (i % BANKS == b) n++;
        return n;
    endfunction

    function automatic logic model_enq_rdy();
        return bank_occ(n_enq % BANKS) < DEPTH;
    endfunction

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        n_enq = 0;
        n_deq = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".count"}, WIDTH'(count), WIDTH'(q.size()));
        chk({tag, ".enq_rdy"}, WIDTH'(enq_rdy), WIDTH'(model_enq_rdy()));
        chk({tag, ".deq_rdy"}, WIDTH'(deq_rdy), WIDTH'(q.size() != 0));
        chk({tag, ".first_rdy"}, WIDTH'(first_rdy), WIDTH'(q.size() != 0));
        if (q.size() != 0) chk({tag, ".first"}, first, q[0]);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, ".count"}, WIDTH'(count), '0);
        chk({tag, ".enq_rdy"}, WIDTH'(enq_rdy), WIDTH'(1));
        chk({tag, ".deq_rdy"}, WIDTH'(deq_rdy), '0);
        chk({tag, ".first_rdy"}, WIDTH'(first_rdy), '0);
        chk({tag, ".first"}, first, '0);
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic cycle(input string tag, input logic e, input logic [WIDTH-1:0] d,
                         input logic r, input logic f);
        logic er, dr;
        enq_ena   = e;
        enq_data  = d;
        deq_ena   = r;
        flush_ena = f;
        #1;
        check_outputs(tag);
        er = model_enq_rdy();
        dr = (q.size() != 0);
        if (e && !er) $display("warning: %s enq strobe while not ready", tag);
        if (r && !dr) $display("warning: %s deq strobe while not ready", tag);
        @(posedge clk);
        if (f) begin
            model_clear();
        end else begin
            if (r && dr) begin
                void'(q.pop_front());
                n_deq++;
            end
            if (e && er) begin
                q.push_back(d);
                n_enq++;
            end
        end
        @(negedge clk);
        enq_ena   = 1'b0;
        deq_ena   = 1'b0;
        flush_ena = 1'b0;
    endtask

    function automatic logic [WIDTH-1:0] rnd_data();
        return {$urandom, $urandom, $urandom};
    endfunction

    initial begin
        rst_n = 1'b0;
        enq_ena = 1'b0;
        deq_ena = 1'b0;
        flush_ena = 1'b0;
        enq_data = '0;
        model_clear();
        repeat (2) @(negedge clk);
        #1;
        check_reset_values("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Fill: six back-to-back enqueues, then a seventh that must be refused.
        for (int i = 1; i <= CAP; i++) cycle("fill", 1'b1, WIDTH'(i), 1'b0, 1'b0);
        cycle("fill_full", 1'b1, WIDTH'(7), 1'b0, 1'b0);
        chk("full.count", WIDTH'(count), WIDTH'(CAP));
        chk("full.enq_rdy", WIDTH'(enq_rdy), '0);

        // Full + simultaneous enq/deq: only deq completes, enq goes in next cycle.
        cycle("full_both", 1'b1, WIDTH'(8'h77), 1'b1, 1'b0);
        cycle("full_retry", 1'b1, WIDTH'(8'h77), 1'b0, 1'b0);

        // Drain: head sequence 2..6 then 0x77.
        for (int i = 0; i < CAP; i++) cycle("drain", 1'b0, '0, 1'b1, 1'b0);
        chk("empty.first_rdy", WIDTH'(first_rdy), '0);
        chk("empty.count", WIDTH'(count), '0);

        // Streaming with one entry resident.
        cycle("stream_prime", 1'b1, rnd_data(), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cycle("stream", 1'b1, rnd_data(), 1'b1, 1'b0);
        chk("stream.count", WIDTH'(count), WIDTH'(1));

        // Flush with four entries while enq and deq are also strobed.
        for (int i = 0; i < 3; i++) cycle("pre_flush", 1'b1, rnd_data(), 1'b0, 1'b0);
        chk("pre_flush.count", WIDTH'(count), WIDTH'(4));
        cycle("flush", 1'b1, rnd_data(), 1'b1, 1'b1);
        chk("flush.count", WIDTH'(count), '0);
        chk("flush.first_rdy", WIDTH'(first_rdy), '0);
        chk("flush.enq_rdy", WIDTH'(enq_rdy), WIDTH'(1));
        cycle("post_flush_enq", 1'b1, WIDTH'(8'hA), 1'b0, 1'b0);
        chk("post_flush.first", first, WIDTH'(8'hA));
        cycle("post_flush_deq", 1'b0, '0, 1'b1, 1'b0);

        // Asynchronous reset between edges, mid-stream.
        for (int i = 0; i < 4; i++) cycle("pre_rst", 1'b1, rnd_data(), 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_rst");
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        cycle("post_rst_enq", 1'b1, WIDTH'(8'hB), 1'b0, 1'b0);
        chk("post_rst.first", first, WIDTH'(8'hB));
        cycle("post_rst_deq", 1'b0, '0, 1'b1, 1'b0);

        // Random traffic with occasional flush.
        for (int i = 0; i < 400; i++)
            cycle("rand", 1'($urandom_range(0, 99) < 60), rnd_data(),
                  1'($urandom_range(0, 99) < 50), 1'($urandom_range(0, 99) < 3));
        check_outputs("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
